// File: rtl/seven_segment_scanner.sv
// Four-digit multiplexed seven-segment scanner: one digit per prescaler slot, a blank gap at
// the start of every slot, and digit inputs captured once per frame so a frame never tears.
module seven_segment_scanner #(
    parameter int REFRESH_DIV  = 25000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        cmosClock,
    input  logic        reset,
    input  logic [15:0] digitsIn,
    input  logic [3:0]  decimalPointsIn,
    input  logic        blankLeadingZeros,
    output logic [3:0]  sevenSegmentEnable,
    output logic [7:0]  sevenSegmentData,
    output logic        frameStart
);

    localparam int            CW        = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);

    logic [CW-1:0] count;
    logic [1:0]    digit_index;
    logic [15:0]   shadow_digits;
    logic [3:0]    shadow_points;
    logic          shadow_blank;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    current_digit;
    logic [3:0]    blank_mask;
    logic [3:0]    next_enable;
    logic [7:0]    next_data;

    function automatic logic [6:0] hex_decode(input logic [3:0] value);
        case (value)
            4'h0:    hex_decode = 7'h3F;
            4'h1:    hex_decode = 7'h06;
            4'h2:    hex_decode = 7'h5B;
            4'h3:    hex_decode = 7'h4F;
            4'h4:    hex_decode = 7'h66;
            4'h5:    hex_decode = 7'h6D;
            4'h6:    hex_decode = 7'h7D;
            4'h7:    hex_decode = 7'h07;
            4'h8:    hex_decode = 7'h7F;
            4'h9:    hex_decode = 7'h6F;
            4'hA:    hex_decode = 7'h77;
            4'hB:    hex_decode = 7'h7C;
            4'hC:    hex_decode = 7'h39;
            4'hD:    hex_decode = 7'h5E;
            4'hE:    hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    assign slot_end      = (count == SLOT_LAST);
    assign frame_end     = slot_end && (digit_index == 2'd3);
    assign current_digit = shadow_digits[{digit_index, 2'b00} +: 4];

    // A digit is a leading zero only if every digit from it upward is zero with no DP lit;
    // the chain runs top-down so one DP releases all digits beneath it.
    always_comb begin
        blank_mask[3] = shadow_blank && (shadow_digits[15:12] == 4'h0) && !shadow_points[3];
        blank_mask[2] = blank_mask[3] && (shadow_digits[11:8] == 4'h0) && !shadow_points[2];
        blank_mask[1] = blank_mask[2] && (shadow_digits[7:4] == 4'h0) && !shadow_points[1];
        blank_mask[0] = 1'b0;
    end

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
        next_enable = 4'b1111;
        next_data   = 8'hFF;
        if (count >= BLANK_END && !blank_mask[digit_index]) begin
            next_enable = ~(4'b0001 << digit_index);
            next_data   = ~{shadow_points[digit_index], hex_decode(current_digit)};
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge state together.
    always_ff @(posedge cmosClock) begin
        if (reset) begin
            count              <= '0;
            digit_index        <= 2'd0;
            // NOTE: shadow registers are reset so the first frame shows a defined "0000".
            shadow_digits      <= 16'h0000;
            shadow_points      <= 4'h0;
            shadow_blank       <= 1'b0;
            sevenSegmentEnable <= 4'b1111;
            sevenSegmentData   <= 8'hFF;
            frameStart         <= 1'b0;
        end else begin
            count              <= slot_end ? '0 : count + 1'b1;
            digit_index        <= slot_end ? digit_index + 2'd1 : digit_index;
            sevenSegmentEnable <= next_enable;
            sevenSegmentData   <= next_data;
            frameStart         <= frame_end;
            if (frame_end) begin
                shadow_digits <= digitsIn;
                shadow_points <= decimalPointsIn;
                shadow_blank  <= blankLeadingZeros;
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: directed scenarios plus random traffic, all
// compared cycle by cycle against a frame-position reference model.
module tb_seven_segment_scanner;

    localparam int RD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 4 * RD;

    localparam logic [6:0] HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] digits;
    logic [3:0]  points;
    logic        blz;
    logic [3:0]  en;
    logic [7:0]  data;
    logic        fs;

    int checks = 0;
    int errors = 0;

    // Reference model: position within the 32-cycle frame plus the latched frame inputs.
    int          pos;
    logic [15:0] sh_digits;
    logic [3:0]  sh_points;
    logic        sh_blz;
    logic [3:0]  exp_en;
    logic [7:0]  exp_data;
    logic        exp_fs;
    logic        exp_gap;

    seven_segment_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
        .cmosClock         (clk),
        .reset             (reset),
        .digitsIn          (digits),
        .decimalPointsIn   (points),
        .blankLeadingZeros (blz),
        .sevenSegmentEnable(en),
        .sevenSegmentData  (data),
        .frameStart        (fs)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic model_edge();
        int  slot;
        int  cnt;
        bit  blanked;
        if (reset) begin
            exp_en = 4'hF; exp_data = 8'hFF; exp_fs = 1'b0; exp_gap = 1'b0;
            pos = 0; sh_digits = '0; sh_points = '0; sh_blz = 1'b0;
        end else begin
            slot    = pos / RD;
            cnt     = pos % RD;
            exp_gap = (cnt < BC);
            blanked = 1'b0;
            if (sh_blz && slot > 0) begin
                blanked = 1'b1;
                for (int n = slot; n < 4; n++)
                    if (sh_digits[4*n +: 4] != 4'h0 || sh_points[n]) blanked = 1'b0;
            end
            if (exp_gap || blanked) begin
                exp_en = 4'hF; exp_data = 8'hFF;
            end else begin
                exp_en = 4'hF;
                exp_en[slot] = 1'b0;
                exp_data = ~{sh_points[slot], HEX[sh_digits[4*slot +: 4]]};
            end
            exp_fs = (pos == FRAME - 1);
            if (exp_fs) begin
                sh_digits = digits; sh_points = points; sh_blz = blz;
            end
            pos = (pos + 1) % FRAME;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("enable", en, exp_en);
        check("data", data, exp_data);
        check("frame_start", fs, exp_fs);
        check("one_enable_low", 16'($countones(~en) <= 1), 16'd1);
        if (exp_gap) check("gap_enable_off", en, 4'hF);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_fs(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            n++;
            if (fs === 1'b1) break;
        end
        check("frame_start_seen", fs, 1'b1);
    endtask

    initial begin
        int n;
        logic [3:0] nib;
        reset = 1'b1; digits = '0; points = '0; blz = 1'b0;
        pos = 0; sh_digits = '0; sh_points = '0; sh_blz = 1'b0;
        run(2);
        check("reset_enable", en, 4'hF);
        check("reset_data", data, 8'hFF);
        check("reset_frame_start", fs, 1'b0);

        // Plain four-digit value, no blanking
        reset = 1'b0; digits = 16'h1234;
        wait_fs(n);
        check("first_latch_delay", n, FRAME);
        run(3);
        check("t1_d0_enable", en, 4'hE);
        check("t1_d0_data", data, 8'h99);
        run(24);
        check("t1_d3_enable", en, 4'h7);
        check("t1_d3_data", data, 8'hF9);

        // Leading-zero blanking
        digits = 16'h00A5; blz = 1'b1;
        wait_fs(n);
        run(3);
        check("t2_d0_data", data, 8'h92);
        run(8);
        check("t2_d1_data", data, 8'h88);
        run(8);
        check("t2_d2_off", en, 4'hF);
        digits = 16'h0000;
        wait_fs(n);
        run(3);
        check("t2_zero_d0", data, 8'hC0);
        run(8);
        check("t2_zero_d1_off", en, 4'hF);

        // Decimal point releases blanking of its digit and those below
        digits = 16'h0005; points = 4'b0100;
        wait_fs(n);
        run(11);
        check("t3_d1_data", data, 8'hC0);
        run(8);
        check("t3_d2_enable", en, 4'hB);
        check("t3_d2_data", data, 8'h40);
        run(8);
        check("t3_d3_off", en, 4'hF);

        // Mid-frame input change stays invisible until the next frame
        wait_fs(n);
        run(10);
        digits = 16'hFFFF; points = 4'h0; blz = 1'b0;
        run(9);
        check("t4_old_d2_data", data, 8'h40);
        wait_fs(n);
        wait_fs(n);
        check("t4_frame_period", n, FRAME);
        run(3);
        check("t4_new_d0_data", data, 8'h8E);

        // Reset in slot 2, count 5
        run(18);
        reset = 1'b1;
        step();
        check("t5_enable", en, 4'hF);
        check("t5_data", data, 8'hFF);
        reset = 1'b0;
        run(3);
        check("t5_restart_enable", en, 4'hE);
        check("t5_restart_data", data, 8'hC0);
        wait_fs(n);
        check("t5_restart_latch", n, FRAME - 3);

        // Every hex code on all digits
        for (int v = 0; v < 16; v++) begin
            nib = 4'(v);
            digits = {4{nib}};
            wait_fs(n);
            run(3);
            check("hex_decode", data, {8'h00, ~{1'b0, HEX[v]}});
        end

        // Random traffic, occasional resets
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(7) == 0) begin
                digits = 16'($urandom);
                points = 4'($urandom);
                blz    = 1'($urandom);
            end
            reset = ($urandom_range(199) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
